load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised, handshaked load/store unit between the execute stage and the data-memory bus. It accepts one memory operation at a time, aligns store data and byte strobes to the addressed lanes, and issues a single bus transaction. It then sign- or zero-extends returned load data and reports misaligned-address, access-fault and illegal-width exceptions. It supersedes the purely combinational access decoder with a real request/response protocol, XLEN generality and fault handling.

## Interface
- XLEN, 32, data width; 32 or 64
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only when LSU_TIMEOUT_EN is defined
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  operation offered by the pipeline
- req_ready  out  1  unit can accept; high only in IDLE
- req_type  in  4  common::access_type_t (LB LH LW LD LBU LHU LWU SB SH SW SD)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  result available
- resp_ready  in  1  pipeline consumes result
- resp_rdata  out  XLEN  extended load data; 0 for stores and exceptions
- resp_exc  out  1  exception flag
- resp_cause  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared
- bus_wdata  out  XLEN  lane-shifted store data
- bus_strb  out  XLEN/8  byte strobes
- bus_resp_valid  in  1  bus response (read data or write ack)
- bus_resp_rdata  in  XLEN  raw read data
- bus_resp_err  in  1  bus error
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, WAIT, RESP (common::lsu_state_t).
- IDLE: req_ready=1. On req_valid, capture all req_* fields.
  - If width is illegal (LD/SD/LWU with XLEN=32, or an unknown encoding), go to RESP with cause 2.
  - If addr is not size-aligned, go to RESP with cause 4 (loads) or 6 (stores). No bus traffic occurs.
  - Otherwise go to REQ.
- REQ: bus_req_valid=1 and all bus_* held stable until bus_req_ready. On the handshake, go to WAIT.
- WAIT: on bus_resp_valid, capture the result and go to RESP.
  - bus_resp_err=1 gives cause 5 (loads) or 7 (stores) with resp_rdata=0.
  - Stores also wait for bus_resp_valid as a write acknowledgement.
- RESP: resp_valid=1 with outputs stable until resp_ready, then go to IDLE.
- Lane math: off = addr[log2(XLEN/8)-1:0].
  - bus_strb = size_mask << off, where size_mask is 1, 3, 0xF or 0xFF.
  - bus_wdata = req_wdata << (8*off).
  - Load: r = bus_resp_rdata >> (8*off), truncated to the access size. Sign-extend from bit 7/15/31 for LB/LH/LW. Zero-extend for LBU/LHU/LWU. LD is passed through.
- bus_resp_valid outside WAIT is ignored.
- Reset outputs: req_ready=0 during reset and 1 from the first post-reset cycle. Every other output is 0 and the state is IDLE.
- Reset mid-operation abandons the transaction. The bus slave must share rst_n.

## Timing
- Accept at cycle 0 → bus_req_valid at cycle 1.
- bus_resp_valid is legal no earlier than the cycle after the bus handshake. resp_valid rises the cycle after bus_resp_valid.
- Minimum latency with a zero-wait bus: accept 0, bus handshake 1, bus response 2, resp_valid 3.
- Exception paths: resp_valid at cycle 1, no bus activity.
- Throughput is one operation per (latency + 1) cycles. There is no overlap and nothing is ever outstanding beyond one.
- All outputs are registered or derived from the state and captured registers only. There is no combinational path from req_* to bus_*.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears when entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES, go to RESP with cause 5 or 7 and drop bus_req_valid.
  - A late bus_resp_valid is then ignored.
- Undefined: no counter; the unit waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Package common holds:
  - access_type_t encoding (shared with the decoder)
  - lsu_state_t
  - exception cause constants (EXC_ILLEGAL=2, EXC_LD_MISALIGN=4, EXC_LD_FAULT=5, EXC_ST_MISALIGN=6, EXC_ST_FAULT=7)
- Sub-module lsu_align is purely combinational: store lane shift and strobes, load shift and extension, misalignment and illegal-width check. It is instantiated once, fed from the captured request registers.

## Test plan
- XLEN=32, LB addr 0x1003, bus returns 0x80FF_FFFF → resp_rdata 0xFFFF_FF80, resp_exc 0, bus_addr 0x1000, resp_valid at cycle 3.
- SH addr 0x2002 wdata 0x0000_ABCD → bus_strb 0b1100, bus_wdata 0xABCD_0000, bus_we 1; after ack, resp_exc 0.
- LW addr 0x3001 → resp_exc 1, cause 4, resp_valid at cycle 1, bus_req_valid never asserted; LD with XLEN=32 → cause 2.
- LHU addr 0x4000, bus_req_ready low 5 cycles, then bus_resp_err=1 → bus_* stable through the stall, resp cause 5, resp_rdata 0.
- resp_ready held low 4 cycles → resp_* stable, req_ready 0; rst_n low during WAIT → all outputs 0 next cycle, IDLE, stale bus_resp_valid ignored.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, SW with no bus response → cause 7 after 8 cycles in REQ/WAIT; XLEN=64 LWU addr 0x4 with rdata 0x8000_0000_0000_0000 → 0x0000_0000_8000_0000.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the access decoder.
//   access_type_t : 4-bit memory access encoding; bit 3 = store, bits 1:0 = log2(size)
//   lsu_state_t   : load/store unit FSM states
//   EXC_*         : exception cause codes reported on resp_cause
//   access_size / check_access : helpers for size and exception detection
package common;

    typedef enum logic [3:0] {
        LB  = 4'h0,
        LH  = 4'h1,
        LW  = 4'h2,
        LD  = 4'h3,
        LBU = 4'h4,
        LHU = 4'h5,
        LWU = 4'h6,
        SB  = 4'h8,
        SH  = 4'h9,
        SW  = 4'hA,
        SD  = 4'hB
    } access_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // The encoding is laid out so the low two bits are log2 of the access size.
    function automatic logic [1:0] access_size(input logic [3:0] t);
        return t[1:0];
    endfunction

    // Returns {exc, cause}. Illegal width wins over misalignment.
    // off is the byte offset within the data word, zero-padded to 3 bits.
    function automatic logic [4:0] check_access(input logic [3:0] t,
                                                input logic [2:0] off,
                                                input logic       wide);
        logic       legal;
        logic [2:0] amask;
        legal = !(t == 4'h7 || t > 4'hB) &&
                (wide || !(t == LD || t == SD || t == LWU));
        amask = 3'((4'd1 << access_size(t)) - 4'd1);
        if (!legal)
            return {1'b1, EXC_ILLEGAL};
        if ((off & amask) != 3'd0)
            return {1'b1, t[3] ? EXC_ST_MISALIGN : EXC_LD_MISALIGN};
        return 5'd0;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   acc_type : captured access type
//   off      : byte offset of the access within the data word
//   st_data  : right-aligned store data   -> st_lanes : store data moved onto its byte lanes
//                                          -> strb     : byte strobes for the access
//   ld_raw   : raw bus read data          -> ld_data  : shifted down and sign/zero extended
module lsu_align
    import common::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]                 acc_type,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            st_data,
    output logic [XLEN-1:0]            st_lanes,
    output logic [XLEN/8-1:0]          strb,
    input  logic [XLEN-1:0]            ld_raw,
    output logic [XLEN-1:0]            ld_data
);
    localparam int NB = XLEN / 8;

    logic [7:0]      size_mask;
    logic [XLEN-1:0] sh;

    always_comb begin
        case (access_size(acc_type))
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // A doubleword mask truncates harmlessly at XLEN=32; that width is rejected as illegal anyway.
    assign strb     = NB'(size_mask) << off;
    assign st_lanes = st_data << {off, 3'b000};
    assign sh       = ld_raw >> {off, 3'b000};

    // Size casts of signed operands sign-extend, unsigned ones zero-extend.
    always_comb begin
        case (access_type_t'(acc_type))
            LB:      ld_data = XLEN'($signed(sh[7:0]));
            LH:      ld_data = XLEN'($signed(sh[15:0]));
            LW:      ld_data = XLEN'($signed(sh[31:0]));
            LBU:     ld_data = XLEN'(sh[7:0]);
            LHU:     ld_data = XLEN'(sh[15:0]);
            LWU:     ld_data = XLEN'(sh[31:0]);
            LD:      ld_data = sh;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine between execute and the data-memory bus.
// Accepts an operation (req_*), checks width/alignment, issues one bus transaction
// (bus_req_* / bus_resp_*), and returns extended load data or an exception (resp_*).
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/ready/type/addr/wdata : operation from the pipeline
//   resp_valid/ready/rdata/exc/cause: result to the pipeline
//   bus_req_valid/ready, bus_we/addr/wdata/strb : bus request
//   bus_resp_valid/rdata/err          : bus response (read data or write ack)
//   busy                    : high whenever not IDLE
// Optional feature: define LSU_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES
// cycles in REQ/WAIT with a fault cause; otherwise the unit waits indefinitely.
module load_store_unit
    import common::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_exc,
    output logic [3:0]        resp_cause,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_strb,
    input  logic              bus_resp_valid,
    input  logic [XLEN-1:0]   bus_resp_rdata,
    input  logic              bus_resp_err,
    output logic              busy
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("load_store_unit: XLEN must be 32 or 64 and TIMEOUT_CYCLES at least 1");
    end

    lsu_state_t        state_q, state_d;
    logic [3:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              exc_q;
    logic [3:0]        cause_q;

    logic              acc_exc;
    logic [3:0]        acc_cause;
    logic              tmo;
    logic              in_req, in_resp, is_store;
    logic [3:0]        fault_cause;
    logic [XLEN-1:0]   al_wdata, al_rdata;
    logic [NB-1:0]     al_strb;

    // Exception screening looks at the live request so faulting ops reach RESP in one cycle.
    assign {acc_exc, acc_cause} = check_access(req_type, 3'(req_addr[OFF_W-1:0]), XLEN == 64);

    assign in_req      = (state_q == REQ);
    assign in_resp     = (state_q == RESP);
    assign is_store    = type_q[3];
    assign fault_cause = is_store ? EXC_ST_FAULT : EXC_LD_FAULT;

    lsu_align #(.XLEN(XLEN)) u_align (
        .acc_type (type_q),
        .off      (addr_q[OFF_W-1:0]),
        .st_data  (wdata_q),
        .st_lanes (al_wdata),
        .strb     (al_strb),
        .ld_raw   (bus_resp_rdata),
        .ld_data  (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt_q <= '0;
        else if (state_q == IDLE)
            tmo_cnt_q <= '0;
        else if (state_q == REQ || state_q == WAIT)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // Fires during the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
    assign tmo = (state_q == REQ || state_q == WAIT) &&
                 (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A handshake or response arriving in the timeout cycle takes priority over the abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)          state_d = acc_exc ? RESP : REQ;
            REQ:  if (bus_req_ready)      state_d = WAIT;
                  else if (tmo)           state_d = RESP;
            WAIT: if (bus_resp_valid || tmo) state_d = RESP;
            RESP: if (resp_ready)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    type_q  <= req_type;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    exc_q   <= acc_exc;
                    cause_q <= acc_cause;
                end
                REQ: if (tmo && !bus_req_ready) begin
                    exc_q   <= 1'b1;
                    cause_q <= fault_cause;
                end
                WAIT: if (bus_resp_valid) begin
                    exc_q   <= bus_resp_err;
                    cause_q <= bus_resp_err ? fault_cause : 4'd0;
                    rdata_q <= (bus_resp_err || is_store) ? '0 : al_rdata;
                end else if (tmo) begin
                    exc_q   <= 1'b1;
                    cause_q <= fault_cause;
                end
                default: ;
            endcase
        end
    end

    // Outputs come only from state and captured registers; bus/resp fields read 0 outside their phase.
    assign req_ready     = rst_n && (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus_req_valid = in_req;
    assign bus_we        = in_req && is_store;
    assign bus_addr      = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus_wdata     = (in_req && is_store) ? al_wdata : '0;
    assign bus_strb      = in_req ? al_strb : '0;
    assign resp_valid    = in_resp;
    assign resp_rdata    = in_resp ? rdata_q : '0;
    assign resp_exc      = in_resp && exc_q;
    assign resp_cause    = in_resp ? cause_q : 4'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: XLEN=32 main instance driven through a
// scoreboard of expected responses, plus an XLEN=64 instance for wide-lane cases.
// With LSU_TIMEOUT_EN defined, the bus watchdog abort is exercised as well.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [3:0]  resp_cause;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_resp_valid, bus_resp_err;
    logic [31:0] bus_resp_rdata;
    logic        busy;

    logic        w_req_valid, w_req_ready;
    logic [3:0]  w_req_type;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_resp_valid, w_resp_ready;
    logic [63:0] w_resp_rdata;
    logic        w_resp_exc;
    logic [3:0]  w_resp_cause;
    logic        w_bus_req_valid, w_bus_req_ready, w_bus_we;
    logic [31:0] w_bus_addr;
    logic [63:0] w_bus_wdata;
    logic [7:0]  w_bus_strb;
    logic        w_bus_resp_valid, w_bus_resp_err;
    logic [63:0] w_bus_resp_rdata;
    logic        w_busy;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .resp_cause(resp_cause),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
        .bus_resp_err(bus_resp_err), .busy(busy)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_type(w_req_type),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_rdata(w_resp_rdata),
        .resp_exc(w_resp_exc), .resp_cause(w_resp_cause),
        .bus_req_valid(w_bus_req_valid), .bus_req_ready(w_bus_req_ready), .bus_we(w_bus_we),
        .bus_addr(w_bus_addr), .bus_wdata(w_bus_wdata), .bus_strb(w_bus_strb),
        .bus_resp_valid(w_bus_resp_valid), .bus_resp_rdata(w_bus_resp_rdata),
        .bus_resp_err(w_bus_resp_err), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every accepted response is compared against the queue head.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", 64'(resp_rdata), 64'(e.rdata));
                chk("sb_exc",   64'(resp_exc),   64'(e.exc));
                chk("sb_cause", 64'(resp_cause), 64'(e.cause));
            end
        end
    end

    // One operation on the 32-bit unit. Starts and ends just after a rising edge with the unit idle.
    task automatic op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input int stall, input int rstall,
                      input logic use_bus, input logic [31:0] x_rdata, input logic x_exc,
                      input logic [3:0] x_cause, input logic [31:0] x_wdata, input logic [3:0] x_strb);
        sb.push_back('{x_rdata, x_exc, x_cause});
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
        bus_req_ready = (stall == 0);
        @(negedge clk); chk("req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_type = 4'h0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5555_5555;
        if (!use_bus) begin
            @(negedge clk);
            chk("exc_no_bus",  64'(bus_req_valid), 64'd0);
            chk("exc_latency", 64'(resp_valid),    64'd1);
        end else begin
            for (int i = 0; i <= stall; i++) begin
                @(negedge clk);
                chk("bus_req_valid", 64'(bus_req_valid), 64'd1);
                chk("bus_addr",      64'(bus_addr),      64'({a[31:2], 2'b00}));
                chk("bus_we",        64'(bus_we),        64'(t[3]));
                chk("bus_wdata",     64'(bus_wdata),     64'(x_wdata));
                chk("bus_strb",      64'(bus_strb),      64'(x_strb));
                chk("resp_early",    64'(resp_valid),    64'd0);
                if (i == stall) bus_req_ready = 1'b1;
            end
            @(posedge clk); #1;
            bus_req_ready = 1'b0;
            bus_resp_valid = 1'b1; bus_resp_rdata = rd; bus_resp_err = err;
            @(negedge clk); chk("bus_req_drop", 64'(bus_req_valid), 64'd0);
            @(posedge clk); #1;
            bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
            @(negedge clk); chk("resp_latency", 64'(resp_valid), 64'd1);
        end
        // Responses arriving outside WAIT must not disturb the held result.
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hFFFF_FFFF; bus_resp_err = 1'b1;
        for (int i = 0; i < rstall; i++) begin
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", 64'(resp_rdata), 64'(x_rdata));
            chk("hold_exc",   64'(resp_exc),   64'(x_exc));
            chk("hold_cause", 64'(resp_cause), 64'(x_cause));
            chk("hold_ready", 64'(req_ready),  64'd0);
            @(posedge clk); #1; @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        @(negedge clk);
        chk("resp_done", 64'(resp_valid), 64'd0);
        chk("idle_busy", 64'(busy),       64'd0);
        @(posedge clk); #1;
    endtask

    // One load on the 64-bit unit; its bus accepts immediately.
    task automatic op64(input logic [3:0] t, input logic [31:0] a, input logic [63:0] rd,
                        input logic [31:0] x_addr, input logic [7:0] x_strb, input logic [63:0] x_rdata);
        w_req_valid = 1'b1; w_req_type = t; w_req_addr = a;
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        @(negedge clk);
        chk("w_bus_req_valid", 64'(w_bus_req_valid), 64'd1);
        chk("w_bus_addr",      64'(w_bus_addr),      64'(x_addr));
        chk("w_bus_strb",      64'(w_bus_strb),      64'(x_strb));
        @(posedge clk); #1;
        w_bus_resp_valid = 1'b1; w_bus_resp_rdata = rd;
        @(posedge clk); #1;
        w_bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("w_resp_valid", 64'(w_resp_valid), 64'd1);
        chk("w_resp_rdata", w_resp_rdata,      x_rdata);
        chk("w_resp_exc",   64'(w_resp_exc),   64'd0);
        w_resp_ready = 1'b1;
        @(posedge clk); #1;
        w_resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
        w_req_valid = 1'b0; w_req_type = '0; w_req_addr = '0; w_req_wdata = '0; w_resp_ready = 1'b0;
        w_bus_req_ready = 1'b1; w_bus_resp_valid = 1'b0; w_bus_resp_rdata = '0; w_bus_resp_err = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready),     64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
        chk("rst_resp",      64'(resp_valid),    64'd0);
        chk("rst_strb",      64'(bus_strb),      64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        //  type   addr          wdata         bus rdata     err  stl rstl bus  x_rdata       exc  cause  x_wdata       strb
        op(4'h0, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 0,   0,  0,  1, 32'hFFFF_FF80, 0, 4'd0, 32'h0,        4'b1000);
        op(4'h9, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 0,  0,  0,  1, 32'h0,        0, 4'd0, 32'hABCD_0000, 4'b1100);
        op(4'h2, 32'h0000_3001, 32'h0,        32'h0,        0,   0,  0,  0, 32'h0,        1, 4'd4, 32'h0,        4'b0000);
        op(4'h3, 32'h0000_3000, 32'h0,        32'h0,        0,   0,  0,  0, 32'h0,        1, 4'd2, 32'h0,        4'b0000);
        op(4'h5, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 1,   5,  0,  1, 32'h0,        1, 4'd5, 32'h0,        4'b0011);
        op(4'h2, 32'h0000_5004, 32'h0,        32'hCAFE_F00D, 0,   0,  4,  1, 32'hCAFE_F00D, 0, 4'd0, 32'h0,        4'b1111);
        op(4'hA, 32'h0000_6002, 32'h1111_2222, 32'h0,       0,   0,  0,  0, 32'h0,        1, 4'd6, 32'h0,        4'b0000);
        op(4'h4, 32'h0000_7001, 32'h0,        32'h0000_9A00, 0,   0,  0,  1, 32'h0000_009A, 0, 4'd0, 32'h0,        4'b0010);
        op(4'h1, 32'h0000_7002, 32'h0,        32'h8001_0000, 0,   2,  1,  1, 32'hFFFF_8001, 0, 4'd0, 32'h0,        4'b1100);
        op(4'h8, 32'h0000_7003, 32'h0000_005A, 32'h0,       1,   0,  0,  1, 32'h0,        1, 4'd7, 32'h5A00_0000, 4'b1000);
        op(4'hE, 32'h0000_7000, 32'h0,        32'h0,        0,   0,  0,  0, 32'h0,        1, 4'd2, 32'h0,        4'b0000);
        op(4'h6, 32'h0000_8000, 32'h0,        32'h0,        0,   0,  0,  0, 32'h0,        1, 4'd2, 32'h0,        4'b0000);

        // Reset while waiting on the bus abandons the access; a stale response is ignored.
        req_valid = 1'b1; req_type = 4'h2; req_addr = 32'h0000_9000; bus_req_ready = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; bus_req_ready = 1'b0;
        @(negedge clk); chk("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_busy",  64'(busy),          64'd0);
        chk("mid_rst_ready", 64'(req_ready),     64'd0);
        chk("mid_rst_bus",   64'(bus_req_valid), 64'd0);
        chk("mid_rst_resp",  64'(resp_valid),    64'd0);
        rst_n = 1'b1; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0BAD_0BAD;
        @(posedge clk); #1; bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale_resp",  64'(resp_valid), 64'd0);
        chk("stale_busy",  64'(busy),       64'd0);
        chk("stale_ready", 64'(req_ready),  64'd1);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        begin
            int n;
            sb.push_back('{32'h0, 1'b1, 4'd7});
            req_valid = 1'b1; req_type = 4'hA; req_addr = 32'h0000_6000; req_wdata = 32'h1; bus_req_ready = 1'b1;
            @(posedge clk); #1; req_valid = 1'b0; n = 1;
            @(posedge clk); #1; bus_req_ready = 1'b0; n = 2;
            while (!resp_valid && n < 40) begin
                @(posedge clk); #1; n++;
            end
            chk("tmo_cycle", 64'(n), 64'd9);
            bus_resp_valid = 1'b1; bus_resp_rdata = 32'h7777_7777;
            @(posedge clk); #1; bus_resp_valid = 1'b0; resp_ready = 1'b1;
            @(posedge clk); #1; resp_ready = 1'b0;
            @(negedge clk); chk("tmo_idle", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
`endif

        op64(4'h6, 32'h0000_0004, 64'h8000_0000_0000_0000, 32'h0, 8'hF0, 64'h0000_0000_8000_0000);
        op64(4'h2, 32'h0000_000C, 64'h8765_4321_0000_0000, 32'h8, 8'hF0, 64'hFFFF_FFFF_8765_4321);
        op64(4'h3, 32'h0000_0008, 64'h8123_4567_89AB_CDEF, 32'h8, 8'hFF, 64'h8123_4567_89AB_CDEF);

        repeat (2) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
